// File: rtl/bound_flasher_gen_pkg.sv
// Shared definitions for the bound flasher: state encodings and direction helper.
// The phase output carries the state encoding directly, so the values below are
// externally visible and must stay fixed.
package bound_flasher_pkg;

    localparam int unsigned PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_P1    = 4'd1,
        ST_P2    = 4'd2,
        ST_P3    = 4'd3,
        ST_P4    = 4'd4,
        ST_P5    = 4'd5,
        ST_P6    = 4'd6,
        ST_KICK3 = 4'd7,
        ST_KICK5 = 4'd8,
        ST_HOLD  = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Direction the level moves on the tick that enters state s.
    function automatic dir_e state_dir(input state_e s);
        case (s)
            ST_P1, ST_P3, ST_P5:                     state_dir = DIR_UP;
            ST_P2, ST_P4, ST_P6, ST_KICK3, ST_KICK5: state_dir = DIR_DOWN;
            default:                                 state_dir = DIR_NONE;
        endcase
    endfunction

    // True for the ten defined encodings; anything else is recovered to IDLE.
    function automatic logic state_known(input state_e s);
        state_known = (s <= ST_HOLD);
    endfunction

endpackage

// File: rtl/bound_flasher_gen_if.sv
// Lamp-bar control bundle between the flick source / lamp drivers and the flasher.
//   flick : start / kickback request (master -> slave)
//   pause : freeze request, present only when BF_PAUSE_EN is defined
//   lamps : thermometer-coded lamp bar (slave -> master)
//   busy  : sequence running (slave -> master)
//   phase : current state encoding (slave -> master)
interface bound_flasher_gen_if #(
    parameter int unsigned NUM_LEDS = 16
);
    import bound_flasher_pkg::*;

    logic                flick;
`ifdef BF_PAUSE_EN
    logic                pause;
`endif
    logic [NUM_LEDS-1:0] lamps;
    logic                busy;
    logic [PHASE_W-1:0]  phase;

    modport master (
        output flick,
`ifdef BF_PAUSE_EN
        output pause,
`endif
        input  lamps,
        input  busy,
        input  phase
    );

    modport slave (
        input  flick,
`ifdef BF_PAUSE_EN
        input  pause,
`endif
        output lamps,
        output busy,
        output phase
    );

endinterface

// File: rtl/bound_flasher_gen_step.sv
// step_prescaler: divides clk into one step tick every STEP_DIV cycles.
//   clk   : system clock
//   reset : synchronous active-high reset
//   clr   : holds the count at 0 (used while the flasher is idle)
//   hold  : freezes the count and suppresses tick
//   tick  : high on the cycle the count sits at STEP_DIV-1
module step_prescaler #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned   CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running modulo-STEP_DIV counter with clear and freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tick = !clr && !hold && (r_cnt == CNT_LAST);

endmodule

// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen: six-phase up/down lamp-bar sequencer with flick kickback at
// two bounds (B1, B2). Optional freeze input enabled by defining BF_PAUSE_EN.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset, overrides pause and flick
//   bus   : slave modport of bound_flasher_gen_if (flick, [pause], lamps, busy, phase)
// All outputs are registered decodes of the next state, so flick has no
// combinational path to lamps/busy/phase.
module bound_flasher_gen #(
    parameter int unsigned NUM_LEDS = 16,
    parameter int unsigned B1       = 5,
    parameter int unsigned B2       = 10,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    bound_flasher_gen_if.slave    bus
);
    import bound_flasher_pkg::*;

    localparam int unsigned      LVL_W   = $clog2(NUM_LEDS + 1);
    localparam logic [LVL_W-1:0] LVL_B1  = LVL_W'(B1);
    localparam logic [LVL_W-1:0] LVL_B2  = LVL_W'(B2);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEDS);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    state_e              r_state;
    logic [LVL_W-1:0]    r_level;
    logic [NUM_LEDS-1:0] r_lamps;
    logic                r_busy;

    state_e              w_state_nxt;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [NUM_LEDS-1:0] w_lamps_nxt;
    logic                w_pause;
    logic                w_idle;
    logic                w_tick;
    logic                w_flick;

`ifdef BF_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_flick = bus.flick;
    assign w_idle  = (r_state == ST_IDLE);

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .clr   (w_idle),
        .hold  (w_pause),
        .tick  (w_tick)
    );

    // Next state and level: IDLE starts on flick without a tick, every other
    // state decides on a tick, then the level steps toward the new state.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (!state_known(r_state)) begin
            w_state_nxt = ST_IDLE;
            w_level_nxt = '0;
        end else if (!w_pause) begin
            if (w_idle) begin
                if (w_flick) begin
                    w_state_nxt = ST_P1;
                end
            end else if (w_tick) begin
                case (r_state)
                    ST_P1: if (r_level == LVL_B1) w_state_nxt = ST_P2;
                    ST_P2: if (r_level == '0)     w_state_nxt = ST_P3;
                    // Kickback wins over the normal turn at B2.
                    ST_P3: begin
                        if (w_flick && (r_level == LVL_B1 || r_level == LVL_B2)) begin
                            w_state_nxt = ST_KICK3;
                        end else if (r_level == LVL_B2) begin
                            w_state_nxt = ST_P4;
                        end
                    end
                    ST_KICK3: if (r_level == '0) w_state_nxt = ST_P3;
                    ST_P4, ST_KICK5: begin
                        if (r_level == LVL_B1) begin
                            w_state_nxt = w_flick ? ST_HOLD : ST_P5;
                        end
                    end
                    ST_HOLD: if (!w_flick) w_state_nxt = ST_P5;
                    ST_P5: begin
                        if (w_flick && r_level == LVL_B2) begin
                            w_state_nxt = ST_KICK5;
                        end else if (r_level == LVL_MAX) begin
                            w_state_nxt = ST_P6;
                        end
                    end
                    ST_P6: if (r_level == LVL_ONE) w_state_nxt = ST_IDLE;
                    default: w_state_nxt = ST_IDLE;
                endcase

                case (state_dir(w_state_nxt))
                    DIR_UP:   w_level_nxt = r_level + LVL_ONE;
                    DIR_DOWN: w_level_nxt = r_level - LVL_ONE;
                    default:  w_level_nxt = r_level;
                endcase
                // The final P6 step lands on 0 as the sequence ends.
                if (w_state_nxt == ST_IDLE) begin
                    w_level_nxt = '0;
                end
            end
        end
    end

    // Thermometer decode of the next level.
    always_comb begin
        w_lamps_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_lamps_nxt[i] = (LVL_W'(i) < w_level_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_level <= '0;
            r_lamps <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_lamps <= w_lamps_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.lamps = r_lamps;
    assign bus.busy  = r_busy;
    assign bus.phase = r_state;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Self-checking bench for bound_flasher_gen: a default-parameter instance (A) and a
// STEP_DIV=3 / NUM_LEDS=8 / B1=2 / B2=5 instance (B), each shadowed by a
// cycle-level reference model. Define BF_PAUSE_EN to also exercise pause.
module tb_bound_flasher_gen;

    localparam int A_N = 16, A_B1 = 5, A_B2 = 10, A_DIV = 1;
    localparam int B_N = 8,  B_B1 = 2, B_B2 = 5,  B_DIV = 3;

    logic clk;
    logic rst_a, rst_b;
    logic pz_a, pz_b;

    bound_flasher_gen_if #(.NUM_LEDS(A_N)) if_a ();
    bound_flasher_gen_if #(.NUM_LEDS(B_N)) if_b ();

`ifdef BF_PAUSE_EN
    assign if_a.pause = pz_a;
    assign if_b.pause = pz_b;
`endif

    bound_flasher_gen #(.NUM_LEDS(A_N), .B1(A_B1), .B2(A_B2), .STEP_DIV(A_DIV)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    bound_flasher_gen #(.NUM_LEDS(B_N), .B1(B_B1), .B2(B_B2), .STEP_DIV(B_DIV)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, lamp level and cycles elapsed in the current step.
    typedef struct packed { int ph; int lvl; int pre; } mdl_t;
    mdl_t ma, mb;

    function automatic mdl_t mstep(input mdl_t c, input int n, input int b1, input int b2,
                                   input int div, input logic rst, input logic fl, input logic pz);
        mdl_t r;
        int   np;
        r = c;
        if (rst) begin
            r.ph = 0; r.lvl = 0; r.pre = 0;
            return r;
        end
        if (pz) return r;
        if (c.ph == 0) begin
            r.pre = 0;
            if (fl) r.ph = 1;
            return r;
        end
        if (c.pre != div - 1) begin
            r.pre = c.pre + 1;
            return r;
        end
        r.pre = 0;
        np = c.ph;
        case (c.ph)
            1: if (c.lvl == b1) np = 2;
            2: if (c.lvl == 0) np = 3;
            3: if (fl && (c.lvl == b1 || c.lvl == b2)) np = 7; else if (c.lvl == b2) np = 4;
            7: if (c.lvl == 0) np = 3;
            4, 8: if (c.lvl == b1) np = fl ? 9 : 5;
            9: if (!fl) np = 5;
            5: if (fl && c.lvl == b2) np = 8; else if (c.lvl == n) np = 6;
            6: if (c.lvl == 1) np = 0;
            default: np = 0;
        endcase
        r.ph = np;
        if (np inside {1, 3, 5}) r.lvl = c.lvl + 1;
        else if (np inside {2, 4, 6, 7, 8}) r.lvl = c.lvl - 1;
        if (np == 0) r.lvl = 0;
        return r;
    endfunction

    always @(posedge clk) ma <= mstep(ma, A_N, A_B1, A_B2, A_DIV, rst_a, if_a.flick, pz_a);
    always @(posedge clk) mb <= mstep(mb, B_N, B_B1, B_B2, B_DIV, rst_b, if_b.flick, pz_b);

    function automatic int dut_lvl(input int sel);
        return (sel == 0) ? $countones(if_a.lamps) : $countones(if_b.lamps);
    endfunction

    function automatic int dut_ph(input int sel);
        return (sel == 0) ? int'(if_a.phase) : int'(if_b.phase);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until phase ph (and level lvl unless lvl<0) is seen, within budget cycles.
    task automatic wait_for(input int sel, input int ph, input int lvl, input int budget,
                            output bit ok, output int min_l, output int max_l);
        ok = 1'b0; min_l = 1000; max_l = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (dut_lvl(sel) < min_l) min_l = dut_lvl(sel);
            if (dut_lvl(sel) > max_l) max_l = dut_lvl(sel);
            if (dut_ph(sel) == ph && (lvl < 0 || dut_lvl(sel) == lvl)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.flick = 1'b1; if_b.flick = 1'b1;
        pz_a = 1'b0; pz_b = 1'b0;
        repeat (3) step();
        checks++; if (if_a.lamps !== 16'h0) begin errors++; $display("FAIL reset_lamps_a: got %h expected 0000", if_a.lamps); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", if_a.busy); end
        checks++; if (if_a.phase !== 4'd0) begin errors++; $display("FAIL reset_phase_a: got %0d expected 0", if_a.phase); end
        checks++; if (if_b.lamps !== 8'h0) begin errors++; $display("FAIL reset_lamps_b: got %h expected 00", if_b.lamps); end
        checks++; if (if_b.phase !== 4'd0) begin errors++; $display("FAIL reset_phase_b: got %0d expected 0", if_b.phase); end
        if_a.flick = 1'b0; if_b.flick = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) step();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_a: busy %b expected 0", if_a.busy); end
    endtask

    task automatic test_full_run();
        int busy_cnt, prev, pdir, d, l;
        bit saw_full;
        int turns[$];
        int exp_turns[6] = '{5, 0, 10, 5, 16, 0};
        logic [63:0] ea;
        if_a.flick = 1'b1;
        step();
        if_a.flick = 1'b0;
        checks++; if (if_a.phase !== 4'd1) begin errors++; $display("FAIL start_phase: got %0d expected 1", if_a.phase); end
        busy_cnt = 0; prev = 0; pdir = 0; saw_full = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (if_a.busy !== 1'b1) break;
            busy_cnt++;
            l = dut_lvl(0);
            if (if_a.lamps === 16'hFFFF) saw_full = 1'b1;
            ea = (64'd1 << ma.lvl) - 64'd1;
            checks++; if (64'(if_a.lamps) !== ea) begin errors++; $display("FAIL run_lamps cyc %0d: got %h expected %h", n, if_a.lamps, ea[15:0]); end
            d = (l > prev) ? 1 : (l < prev) ? -1 : 0;
            if (d != 0) begin
                if (pdir != 0 && d != pdir) turns.push_back(prev);
                pdir = d;
            end
            prev = l;
            step();
        end
        turns.push_back(dut_lvl(0));
        checks++; if (busy_cnt != 52) begin errors++; $display("FAIL run_busy_cycles: got %0d expected 52", busy_cnt); end
        checks++; if (!saw_full) begin errors++; $display("FAIL run_peak_full: lamps never reached FFFF"); end
        checks++;
        if (turns.size() != 6) begin
            errors++; $display("FAIL run_turn_count: got %0d expected 6", turns.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (turns[i] != exp_turns[i]) begin errors++; $display("FAIL run_turn_%0d: got %0d expected %0d", i, turns[i], exp_turns[i]); end
            end
        end
    endtask

    task automatic test_kick3();
        bit ok; int mn, mx;
        int kick_lvls[2] = '{5, 10};
        if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_for(0, 3, kick_lvls[k], 100, ok, mn, mx);
            checks++; if (!ok) begin errors++; $display("FAIL kick3_reach_%0d: timeout, phase %0d level %0d", kick_lvls[k], if_a.phase, dut_lvl(0)); end
            if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
            checks++; if (if_a.phase !== 4'd7) begin errors++; $display("FAIL kick3_enter_%0d: phase %0d expected 7", kick_lvls[k], if_a.phase); end
            checks++; if (dut_lvl(0) != kick_lvls[k] - 1) begin errors++; $display("FAIL kick3_step_%0d: level %0d expected %0d", kick_lvls[k], dut_lvl(0), kick_lvls[k] - 1); end
            wait_for(0, 3, -1, 100, ok, mn, mx);
            checks++; if (!ok || mn != 0) begin errors++; $display("FAIL kick3_floor_%0d: min level %0d expected 0", kick_lvls[k], mn); end
            checks++; if (dut_lvl(0) != 1) begin errors++; $display("FAIL kick3_restart_%0d: level %0d expected 1", kick_lvls[k], dut_lvl(0)); end
        end
        wait_for(0, 0, -1, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL kick3_finish: timeout, phase %0d", if_a.phase); end
    endtask

    task automatic test_kick5();
        bit ok; int mn, mx;
        if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
        wait_for(0, 5, 10, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL kick5_reach: timeout, phase %0d level %0d", if_a.phase, dut_lvl(0)); end
        if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
        checks++; if (if_a.phase !== 4'd8 || dut_lvl(0) != 9) begin errors++; $display("FAIL kick5_enter: phase %0d level %0d expected 8/9", if_a.phase, dut_lvl(0)); end
        wait_for(0, 5, -1, 100, ok, mn, mx);
        checks++; if (!ok || mn != 5 || dut_lvl(0) != 6) begin errors++; $display("FAIL kick5_resume: min %0d level %0d expected 5/6", mn, dut_lvl(0)); end
        wait_for(0, 6, -1, 100, ok, mn, mx);
        checks++; if (!ok || mx != 16 || dut_lvl(0) != 15) begin errors++; $display("FAIL kick5_peak: max %0d level %0d expected 16/15", mx, dut_lvl(0)); end
        wait_for(0, 0, -1, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL kick5_finish: timeout, phase %0d", if_a.phase); end
    endtask

    task automatic test_hold();
        bit ok; int mn, mx;
        if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
        wait_for(0, 4, -1, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL hold_reach_p4: timeout, phase %0d", if_a.phase); end
        if_a.flick = 1'b1;
        wait_for(0, 9, -1, 50, ok, mn, mx);
        checks++; if (!ok || dut_lvl(0) != 5) begin errors++; $display("FAIL hold_enter: phase %0d level %0d expected 9/5", if_a.phase, dut_lvl(0)); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (if_a.phase !== 4'd9 || if_a.lamps !== 16'h001F) begin errors++; $display("FAIL hold_stay_%0d: phase %0d lamps %h expected 9/001F", k, if_a.phase, if_a.lamps); end
        end
        if_a.flick = 1'b0;
        step();
        checks++; if (if_a.phase !== 4'd5 || dut_lvl(0) != 6) begin errors++; $display("FAIL hold_release: phase %0d level %0d expected 5/6", if_a.phase, dut_lvl(0)); end
        wait_for(0, 0, -1, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL hold_finish: timeout, phase %0d", if_a.phase); end
    endtask

`ifdef BF_PAUSE_EN
    task automatic test_pause();
        bit ok; int mn, mx, rem;
        pz_a = 1'b1; if_a.flick = 1'b1;
        step();
        checks++; if (if_a.phase !== 4'd0) begin errors++; $display("FAIL pause_idle_start: phase %0d expected 0", if_a.phase); end
        pz_a = 1'b0; if_a.flick = 1'b0;
        step();
        if_a.flick = 1'b1; step(); if_a.flick = 1'b0;
        wait_for(0, 5, 8, 200, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL pause_reach: timeout, phase %0d level %0d", if_a.phase, dut_lvl(0)); end
        pz_a = 1'b1; if_a.flick = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++; if (if_a.phase !== 4'd5 || if_a.lamps !== 16'h00FF) begin errors++; $display("FAIL pause_frozen_%0d: phase %0d lamps %h expected 5/00FF", k, if_a.phase, if_a.lamps); end
        end
        pz_a = 1'b0; if_a.flick = 1'b0;
        rem = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            rem++;
            if (if_a.busy !== 1'b1) break;
        end
        checks++; if (rem != 24) begin errors++; $display("FAIL pause_remaining: got %0d cycles expected 24", rem); end
    endtask
`endif

    task automatic test_div3();
        bit ok; int mn, mx, prev, cyc, changes, l;
        if_b.flick = 1'b1; step(); if_b.flick = 1'b0;
        checks++; if (if_b.phase !== 4'd1 || if_b.lamps !== 8'h00) begin errors++; $display("FAIL div3_start: phase %0d lamps %h expected 1/00", if_b.phase, if_b.lamps); end
        prev = 0; cyc = 0; changes = 0;
        for (int n = 0; n < 40 && changes < 6; n++) begin
            step();
            cyc++;
            l = dut_lvl(1);
            if (l != prev) begin
                checks++; if (cyc != 3) begin errors++; $display("FAIL div3_interval_%0d: got %0d cycles expected 3", changes, cyc); end
                changes++; cyc = 0; prev = l;
            end
        end
        checks++; if (changes != 6) begin errors++; $display("FAIL div3_changes: got %0d expected 6", changes); end
        wait_for(1, 3, 4, 100, ok, mn, mx);
        checks++; if (!ok) begin errors++; $display("FAIL div3_reach: timeout, phase %0d level %0d", if_b.phase, dut_lvl(1)); end
        rst_b = 1'b1;
        step();
        checks++; if (if_b.phase !== 4'd0 || if_b.lamps !== 8'h00 || if_b.busy !== 1'b0) begin errors++; $display("FAIL div3_midreset: phase %0d lamps %h busy %b expected 0/00/0", if_b.phase, if_b.lamps, if_b.busy); end
        rst_b = 1'b0;
        step();
        checks++; if (if_b.busy !== 1'b0) begin errors++; $display("FAIL div3_after_reset: busy %b expected 0", if_b.busy); end
    endtask

    task automatic test_random();
        int pa, pb;
        logic [63:0] ea, eb;
        pa = 5; pb = 5;
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) begin
                pa = $urandom_range(0, 30);
                pb = $urandom_range(0, 30);
            end
            if_a.flick = ($urandom_range(0, 99) < pa);
            if_b.flick = ($urandom_range(0, 99) < pb);
            rst_a = ($urandom_range(0, 599) == 0);
            rst_b = ($urandom_range(0, 599) == 0);
`ifdef BF_PAUSE_EN
            pz_a = ($urandom_range(0, 15) == 0);
            pz_b = ($urandom_range(0, 15) == 0);
`endif
            step();
            ea = (64'd1 << ma.lvl) - 64'd1;
            eb = (64'd1 << mb.lvl) - 64'd1;
            checks++; if (64'(if_a.lamps) !== ea) begin errors++; $display("FAIL rand_lamps_a cyc %0d: got %h expected %h", n, if_a.lamps, ea[15:0]); end
            checks++; if (if_a.phase !== 4'(ma.ph)) begin errors++; $display("FAIL rand_phase_a cyc %0d: got %0d expected %0d", n, if_a.phase, ma.ph); end
            checks++; if (if_a.busy !== (ma.ph != 0)) begin errors++; $display("FAIL rand_busy_a cyc %0d: got %b expected %b", n, if_a.busy, ma.ph != 0); end
            checks++; if (64'(if_b.lamps) !== eb) begin errors++; $display("FAIL rand_lamps_b cyc %0d: got %h expected %h", n, if_b.lamps, eb[7:0]); end
            checks++; if (if_b.phase !== 4'(mb.ph)) begin errors++; $display("FAIL rand_phase_b cyc %0d: got %0d expected %0d", n, if_b.phase, mb.ph); end
            checks++; if (if_b.busy !== (mb.ph != 0)) begin errors++; $display("FAIL rand_busy_b cyc %0d: got %b expected %b", n, if_b.busy, mb.ph != 0); end
        end
        if_a.flick = 1'b0; if_b.flick = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        pz_a = 1'b0; pz_b = 1'b0;
        step();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        pz_a = 1'b0; pz_b = 1'b0;
        if_a.flick = 1'b0; if_b.flick = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_run();
        test_kick3();
        test_kick5();
        test_hold();
`ifdef BF_PAUSE_EN
        test_pause();
`endif
        test_div3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
